// File: rtl/fp_pkg.sv
// Shared floating-point datapath constants: IEEE-754 single-precision field
// limits, int32 saturation values, rounding-mode and converter state encodings.
package fp_pkg;

  localparam logic [9:0]  FP_BIAS    = 10'd127;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  localparam logic [31:0] INT32_MAX  = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN  = 32'h8000_0000;

  localparam logic RM_RNE   = 1'b0;
  localparam logic RM_TRUNC = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_ROUND = 3'd3,
    ST_DONE  = 3'd4
  } f2i_state_e;

endpackage

// File: rtl/fp_unpack.sv
// Combinational IEEE-754 single-precision field decoder and classifier,
// shared by the float-to-int converter and the adder front end.
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]       a_i,
  output logic              s_o,
  output logic signed [9:0] exp_o,
  output logic [23:0]       man_o,
  output logic              is_zero_o,
  output logic              is_denorm_o,
  output logic              is_inf_o,
  output logic              is_nan_o,
  output logic              is_ovf_o
);

  logic [7:0]  e_s;
  logic [22:0] frac_s;
  logic        exp_max_s;
  logic        exp_zero_s;

  // Field split, unbiased exponent and operand classes
  always_comb begin
    e_s         = a_i[30:23];
    frac_s      = a_i[22:0];
    s_o         = a_i[31];
    exp_o       = $signed({2'b00, e_s} - FP_BIAS);
    exp_max_s   = (e_s == FP_EXP_MAX);
    exp_zero_s  = (e_s == 8'd0);
    man_o       = {~exp_zero_s, frac_s};
    is_zero_o   = exp_zero_s && (frac_s == 23'd0);
    is_denorm_o = exp_zero_s && (frac_s != 23'd0);
    is_inf_o    = exp_max_s && (frac_s == 23'd0);
    is_nan_o    = exp_max_s && (frac_s != 23'd0);
    // -2^31 is the only E=31 value representable in int32
    is_ovf_o    = !exp_max_s &&
                  ((exp_o > 10'sd31) ||
                   ((exp_o == 10'sd31) && !(s_o && (frac_s == 23'd0))));
  end

endmodule

// File: rtl/float_to_int_converter.sv
// Iterative IEEE-754 single to signed int32 converter: one alignment shift per
// clock, then round (RNE or truncate) and sign application.
module float_to_int_converter
  import fp_pkg::*;
#(
  parameter int unsigned MAX_RSHIFT = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic        rmode,
  output logic        busy,
  output logic        done,
  output logic [31:0] res,
  output logic        error,
  output logic        inexact
);

  f2i_state_e  state_q, state_d;
  logic [31:0] a_q, a_d;
  logic        rmode_q, rmode_d;
  logic [31:0] mag_q, mag_d;
  logic        g_q, g_d;
  logic        st_q, st_d;
  logic [7:0]  n_q, n_d;
  logic        left_q, left_d;
  logic        spec_q, spec_d;
  logic        spec_err_q, spec_err_d;
  logic [31:0] spec_res_q, spec_res_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] res_q, res_d;
  logic        error_q, error_d;
  logic        inexact_q, inexact_d;

  logic              s_s;
  logic signed [9:0] exp_s;
  logic [23:0]       man_s;
  logic              is_zero_s, is_denorm_s, is_inf_s, is_nan_s, is_ovf_s;
  logic signed [9:0] lsh_s, rsh_s;

  fp_unpack u_unpack (
    .a_i         (a_q),
    .s_o         (s_s),
    .exp_o       (exp_s),
    .man_o       (man_s),
    .is_zero_o   (is_zero_s),
    .is_denorm_o (is_denorm_s),
    .is_inf_o    (is_inf_s),
    .is_nan_o    (is_nan_s),
    .is_ovf_o    (is_ovf_s)
  );

  // Next-state and datapath for the conversion sequencer
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    rmode_d    = rmode_q;
    mag_d      = mag_q;
    g_d        = g_q;
    st_d       = st_q;
    n_d        = n_q;
    left_d     = left_q;
    spec_d     = spec_q;
    spec_err_d = spec_err_q;
    spec_res_d = spec_res_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    res_d      = res_q;
    error_d    = error_q;
    inexact_d  = inexact_q;
    lsh_s      = exp_s - 10'sd23;
    rsh_s      = 10'sd23 - exp_s;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d       = A;
          rmode_d   = rmode;
          busy_d    = 1'b1;
          error_d   = 1'b0;
          inexact_d = 1'b0;
          state_d   = ST_LOAD;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_LOAD: begin
        mag_d      = {8'd0, man_s};
        g_d        = 1'b0;
        st_d       = 1'b0;
        left_d     = 1'b0;
        spec_d     = 1'b0;
        spec_err_d = 1'b0;
        spec_res_d = INT32_MIN;
        n_d        = 8'd0;
        if (is_nan_s) begin
          spec_d     = 1'b1;
          spec_err_d = 1'b1;
        end else if (is_inf_s || is_ovf_s) begin
          spec_d     = 1'b1;
          spec_err_d = 1'b1;
          spec_res_d = s_s ? INT32_MIN : INT32_MAX;
        end else if (exp_s >= 10'sd31) begin
          spec_d     = 1'b1;
        end else if (is_zero_s || is_denorm_s) begin
          n_d        = 8'(MAX_RSHIFT);
        end else if (exp_s >= 10'sd23) begin
          left_d     = 1'b1;
          n_d        = lsh_s[7:0];
        end else if (rsh_s > $signed(10'(MAX_RSHIFT))) begin
          n_d        = 8'(MAX_RSHIFT);
        end else begin
          n_d        = rsh_s[7:0];
        end
        state_d = (n_d == 8'd0) ? ST_ROUND : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (left_q) begin
          mag_d = {mag_q[30:0], 1'b0};
        end else begin
          st_d  = st_q | g_q;
          g_d   = mag_q[0];
          mag_d = {1'b0, mag_q[31:1]};
        end
        n_d     = n_q - 8'd1;
        state_d = (n_q == 8'd1) ? ST_ROUND : ST_SHIFT;
      end
      ST_ROUND: begin
        // Right-shifted magnitude is below 2^24, so the increment never wraps
        if ((rmode_q == RM_RNE) && g_q && (st_q || mag_q[0])) begin
          mag_d = mag_q + 32'd1;
        end else begin
          mag_d = mag_q;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d    = 1'b1;
        busy_d    = 1'b0;
        error_d   = spec_err_q;
        inexact_d = spec_q ? 1'b0 : (g_q | st_q);
        if (spec_q) begin
          res_d = spec_res_q;
        end else if (s_s) begin
          res_d = 32'd0 - mag_q;
        end else begin
          res_d = mag_q;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight conversion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      a_q        <= 32'd0;
      rmode_q    <= 1'b0;
      mag_q      <= 32'd0;
      g_q        <= 1'b0;
      st_q       <= 1'b0;
      n_q        <= 8'd0;
      left_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_err_q <= 1'b0;
      spec_res_q <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      res_q      <= 32'd0;
      error_q    <= 1'b0;
      inexact_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      rmode_q    <= rmode_d;
      mag_q      <= mag_d;
      g_q        <= g_d;
      st_q       <= st_d;
      n_q        <= n_d;
      left_q     <= left_d;
      spec_q     <= spec_d;
      spec_err_q <= spec_err_d;
      spec_res_q <= spec_res_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      res_q      <= res_d;
      error_q    <= error_d;
      inexact_q  <= inexact_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign res     = res_q;
  assign error   = error_q;
  assign inexact = inexact_q;

endmodule
